// File: rtl/layer_pkg.sv
// Shared constants and FSM encoding for the layer-0 output writer.
package layer_pkg;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned CH_PER_PIX   = 4;
    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned WORD_W       = 128;
    localparam int unsigned BANK_PORTS   = 16;
    localparam int unsigned PIX_W        = DATA_W * CH_PER_PIX;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/out_addr_gen.sv
// Word-column / row tracker for the output writer; maps the current word to a bank and address.
module out_addr_gen
    import layer_pkg::*;
#(
    parameter int unsigned IMG_W    = 32,
    parameter int unsigned IMG_H    = 32,
    parameter int unsigned NUM_BANK = 16,
    parameter int unsigned ADDR_W   = 9
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear_i,
    input  logic                  advance_i,
    output logic [BANK_PORTS-1:0] bank_oh_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic                  last_o
);

    localparam int unsigned WordsPerRow = IMG_W / PIX_PER_WORD;
    localparam int unsigned ColW        = (WordsPerRow > 1) ? $clog2(WordsPerRow) : 1;
    localparam int unsigned RowW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [ColW-1:0] wcol_q, wcol_d;
    logic [RowW-1:0] row_q, row_d;
    logic            col_last, row_last;

    assign col_last = (32'(wcol_q) == WordsPerRow - 1);
    assign row_last = (32'(row_q) == IMG_H - 1);

    always_comb begin
        wcol_d = wcol_q;
        row_d  = row_q;
        if (clear_i) begin
            wcol_d = '0;
            row_d  = '0;
        end else if (advance_i) begin
            if (col_last) begin
                wcol_d = '0;
                row_d  = row_last ? '0 : row_q + 1'b1;
            end else begin
                wcol_d = wcol_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcol_q <= '0;
            row_q  <= '0;
        end else begin
            wcol_q <= wcol_d;
            row_q  <= row_d;
        end
    end

    // Rows are interleaved across banks; each bank holds every NUM_BANK-th row back to back.
    assign bank_oh_o = BANK_PORTS'(1) << (32'(row_q) % NUM_BANK);
    assign addr_o    = ADDR_W'((32'(row_q) / NUM_BANK) * WordsPerRow + 32'(wcol_q));
    assign last_o    = col_last && row_last;

endmodule

// File: rtl/layer00_out_writer.sv
// Packs 4 pixel results per 128-bit word and writes them round-robin into the banked input buffer.
module layer00_out_writer
    import layer_pkg::*;
#(
    parameter int unsigned IMG_W    = 32,
    parameter int unsigned IMG_H    = 32,
    parameter int unsigned NUM_BANK = 16,
    parameter int unsigned ADDR_W   = 9
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_start,
    input  logic                  i_vld,
    input  logic [PIX_W-1:0]      i_data,
    output logic [BANK_PORTS-1:0] o_ena,
    output logic [BANK_PORTS-1:0] o_wea,
    output logic [ADDR_W-1:0]     o_addra,
    output logic [WORD_W-1:0]     o_dia,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    state_e                  state_q;
    logic [1:0]              lane_q;
    logic [3*PIX_W-1:0]      pack_q;
    logic [BANK_PORTS-1:0]   ena_q;
    logic [ADDR_W-1:0]       addra_q;
    logic [WORD_W-1:0]       dia_q;
    logic                    done_q;
    logic                    err_q;

    logic                    emit;
    logic                    clear;
    logic [BANK_PORTS-1:0]   bank_oh;
    logic [ADDR_W-1:0]       addr;
    logic                    last_word;

    assign emit  = (state_q == RUN) && i_vld && (lane_q == 2'd3);
    assign clear = (state_q == IDLE) && i_start;

    out_addr_gen #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .NUM_BANK (NUM_BANK),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rstn      (rstn),
        .clear_i   (clear),
        .advance_i (emit),
        .bank_oh_o (bank_oh),
        .addr_o    (addr),
        .last_o    (last_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            lane_q  <= '0;
            pack_q  <= '0;
            ena_q   <= '0;
            addra_q <= '0;
            dia_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ena_q  <= '0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= RUN;
                        lane_q  <= '0;
                        // A pixel arriving with the start pulse is dropped and flagged.
                        err_q   <= i_vld;
                    end else if (i_vld) begin
                        err_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_vld) begin
                        lane_q <= lane_q + 2'd1;
                        case (lane_q)
                            2'd0: pack_q[0 +: PIX_W]       <= i_data;
                            2'd1: pack_q[PIX_W +: PIX_W]   <= i_data;
                            2'd2: pack_q[2*PIX_W +: PIX_W] <= i_data;
                            2'd3: begin
                                ena_q   <= bank_oh;
                                addra_q <= addr;
                                dia_q   <= {i_data, pack_q};
                                if (last_word) begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (i_vld) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ena   = ena_q;
    assign o_wea   = ena_q;
    assign o_addra = addra_q;
    assign o_dia   = dia_q;
    assign o_busy  = (state_q == RUN);
    assign o_done  = done_q;
    assign o_err   = err_q;

endmodule
